// File: rtl/mul_seq.sv
// Sequential 32x32 shift-and-add multiplier driving an external shared ALU.
// Returns the low 32 bits of the product plus an overflow flag.
module mul_seq (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_product,
  output logic        o_ovf,
  output logic [4:0]  o_alu_op,
  output logic [31:0] o_alu_a,
  output logic [31:0] o_alu_b,
  input  logic [31:0] i_alu_result,
  input  logic        i_alu_c
);

  localparam logic [4:0] AluAdd  = 5'b00000;
  localparam logic [4:0] AluLsl  = 5'b01000;
  localparam logic [4:0] AluIdle = 5'b10000;

  typedef enum logic [1:0] {StIdle, StAdd, StShift, StDone} state_e;

  state_e      r_state, w_state_d;
  logic [31:0] r_acc, w_acc_d;
  logic [31:0] r_mcand, w_mcand_d;
  logic [31:0] r_mplier, w_mplier_d;
  logic [4:0]  r_cnt, w_cnt_d;
  logic        r_ovf, w_ovf_d;
  logic [31:0] r_product, w_product_d;
  logic        r_ovf_out, w_ovf_out_d;
  logic [31:0] w_mplier_shr;
  logic        w_enter_done;

  assign w_mplier_shr = r_mplier >> 1;

  always_comb begin
    w_state_d  = r_state;
    w_acc_d    = r_acc;
    w_mcand_d  = r_mcand;
    w_mplier_d = r_mplier;
    w_cnt_d    = r_cnt;
    w_ovf_d    = r_ovf;
    o_alu_op   = AluIdle;
    o_alu_a    = '0;
    o_alu_b    = '0;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          w_mcand_d  = i_a;
          w_mplier_d = i_b;
          w_acc_d    = '0;
          w_cnt_d    = '0;
          w_ovf_d    = 1'b0;
          w_state_d  = (i_b == '0) ? StDone : StAdd;
        end
      end
      StAdd: begin
        o_alu_op = AluAdd;
        o_alu_a  = r_acc;
        o_alu_b  = r_mcand;
        if (r_mplier[0]) begin
          w_acc_d = i_alu_result;
          w_ovf_d = r_ovf | i_alu_c;
        end
        w_state_d = StShift;
      end
      StShift: begin
        o_alu_op   = AluLsl;
        o_alu_a    = r_mcand;
        o_alu_b    = '0;
        w_mcand_d  = i_alu_result;
        w_mplier_d = w_mplier_shr;
        // A bit shifted out of mcand only matters if a multiplier bit is still pending.
        w_ovf_d    = r_ovf | (i_alu_c & (w_mplier_shr != '0));
        if (r_cnt != 5'd31) w_cnt_d = r_cnt + 5'd1;
        w_state_d  = ((w_mplier_shr == '0) || (r_cnt == 5'd31)) ? StDone : StAdd;
      end
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Results are captured on entry to DONE so they are visible during the done pulse.
  assign w_enter_done = (w_state_d == StDone) && (r_state != StDone);
  assign w_product_d  = w_enter_done ? w_acc_d : r_product;
  assign w_ovf_out_d  = w_enter_done ? w_ovf_d : r_ovf_out;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state   <= StIdle;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_product <= '0;
      r_ovf_out <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_acc     <= w_acc_d;
      r_mcand   <= w_mcand_d;
      r_mplier  <= w_mplier_d;
      r_cnt     <= w_cnt_d;
      r_ovf     <= w_ovf_d;
      r_product <= w_product_d;
      r_ovf_out <= w_ovf_out_d;
    end
  end

  assign o_busy    = (r_state != StIdle);
  assign o_done    = (r_state == StDone);
  assign o_product = r_product;
  assign o_ovf     = r_ovf_out;

endmodule

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq with a behavioural model of the shared ALU.
module tb_mul_seq;

  logic        clk;
  logic        i_reset;
  logic        i_start;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_product;
  logic        o_ovf;
  logic [4:0]  o_alu_op;
  logic [31:0] o_alu_a;
  logic [31:0] o_alu_b;
  logic [31:0] w_alu_result;
  logic        w_alu_c;

  int n_checks = 0;
  int n_errors = 0;

  mul_seq dut (
    .i_clock     (clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_a         (i_a),
    .i_b         (i_b),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_product   (o_product),
    .o_ovf       (o_ovf),
    .o_alu_op    (o_alu_op),
    .o_alu_a     (o_alu_a),
    .o_alu_b     (o_alu_b),
    .i_alu_result(w_alu_result),
    .i_alu_c     (w_alu_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU: add with carry-out, logical shift left by one with the lost bit as carry.
  always_comb begin
    w_alu_result = '0;
    w_alu_c      = 1'b0;
    case (o_alu_op)
      5'b00000: {w_alu_c, w_alu_result} = {1'b0, o_alu_a} + {1'b0, o_alu_b};
      5'b01000: begin
        w_alu_result = o_alu_a << 1;
        w_alu_c      = o_alu_a[31];
      end
      default: ;
    endcase
  end

  // Issues one start pulse from IDLE and follows the run to the done pulse, then returns in
  // the following IDLE cycle. lat is the cycle of the done pulse counted from the accept edge.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, output int lat,
                        output logic [31:0] prod, output logic ovf, output bit saw_add);
    lat = -1;
    prod = '0;
    ovf = 1'b0;
    saw_add = 1'b0;
    i_a = a;
    i_b = b;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (o_alu_op == 5'b00000) saw_add = 1'b1;
      if (o_done) begin
        lat = k;
        prod = o_product;
        ovf = o_ovf;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_start = 1'b0;
    i_a = '0;
    i_b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({o_busy, o_done, o_ovf, o_product} !== 35'd0) begin
      n_errors++;
      $display("FAIL reset_outputs: busy=%b done=%b ovf=%b product=%h, required all 0",
               o_busy, o_done, o_ovf, o_product);
    end
    n_checks++;
    if (o_alu_op !== 5'b10000 || o_alu_a !== 32'd0 || o_alu_b !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_alu: op=%b a=%h b=%h, required op=10000 a=0 b=0",
               o_alu_op, o_alu_a, o_alu_b);
    end
    i_reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic [31:0] p; logic v; bit sa;
    i_a = 32'd3;
    i_b = 32'd5;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1 || o_done !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_busy: busy=%b done=%b after accept, required busy=1 done=0",
               o_busy, o_done);
    end
    // Let the run finish, then repeat it measured from IDLE.
    repeat (10) @(posedge clk);
    #1;
    do_mul(32'd3, 32'd5, lat, p, v, sa);
    n_checks++;
    if (lat !== 7) begin
      n_errors++;
      $display("FAIL basic_latency: done at cycle %0d, required 7", lat);
    end
    n_checks++;
    if (p !== 32'd15 || v !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_result: product=%0d ovf=%b, required 15 ovf=0", p, v);
    end
    n_checks++;
    if (o_product !== 32'd15 || o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_hold: product=%0d busy=%b in IDLE, required 15 busy=0",
               o_product, o_busy);
    end
  endtask

  task automatic test_zero();
    int lat; logic [31:0] p; logic v; bit sa;
    do_mul(32'd123, 32'd0, lat, p, v, sa);
    n_checks++;
    if (lat !== 1 || p !== 32'd0 || v !== 1'b0) begin
      n_errors++;
      $display("FAIL zero_mult: lat=%0d product=%h ovf=%b, required lat=1 product=0 ovf=0",
               lat, p, v);
    end
    n_checks++;
    if (sa !== 1'b0) begin
      n_errors++;
      $display("FAIL zero_no_add: alu add opcode seen=%b, required 0", sa);
    end
  endtask

  task automatic test_overflow();
    int lat; logic [31:0] p; logic v; bit sa;
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, p, v, sa);
    n_checks++;
    if (lat !== 65 || p !== 32'h0000_0001 || v !== 1'b1) begin
      n_errors++;
      $display("FAIL max_operands: lat=%0d product=%h ovf=%b, required lat=65 product=1 ovf=1",
               lat, p, v);
    end
    do_mul(32'h8000_0000, 32'd2, lat, p, v, sa);
    n_checks++;
    if (lat !== 5 || p !== 32'd0 || v !== 1'b1) begin
      n_errors++;
      $display("FAIL shift_loss: lat=%0d product=%h ovf=%b, required lat=5 product=0 ovf=1",
               lat, p, v);
    end
    do_mul(32'h8000_0000, 32'd1, lat, p, v, sa);
    n_checks++;
    if (lat !== 3 || p !== 32'h8000_0000 || v !== 1'b0) begin
      n_errors++;
      $display("FAIL top_bit_no_ovf: lat=%0d product=%h ovf=%b, required 3 80000000 ovf=0",
               lat, p, v);
    end
    do_mul(32'h0001_0000, 32'h0001_0000, lat, p, v, sa);
    n_checks++;
    if (lat !== 35 || p !== 32'd0 || v !== 1'b1) begin
      n_errors++;
      $display("FAIL pow2_ovf: lat=%0d product=%h ovf=%b, required lat=35 product=0 ovf=1",
               lat, p, v);
    end
    do_mul(32'd1000, 32'd1000, lat, p, v, sa);
    n_checks++;
    if (p !== 32'd1000000 || v !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_range: product=%0d ovf=%b, required 1000000 ovf=0", p, v);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    logic [31:0] p1, p2;
    lat1 = -1;
    lat2 = -1;
    p1 = '0;
    p2 = '0;
    i_a = 32'd10;
    i_b = 32'd6;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_a = 32'd3;
    i_b = 32'd4;
    for (int k = 1; k <= 100; k++) begin
      if (o_done) begin
        lat1 = k;
        p1 = o_product;
        break;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (lat1 !== 7 || p1 !== 32'd60) begin
      n_errors++;
      $display("FAIL b2b_first: lat=%0d product=%0d, required lat=7 product=60", lat1, p1);
    end
    // IDLE cycle: start still high is accepted on this edge.
    @(posedge clk); #1;
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_idle: busy=%b in cycle after DONE, required 0", o_busy);
    end
    @(posedge clk); #1;
    i_start = 1'b0;
    n_checks++;
    if (o_busy !== 1'b1 || o_product !== 32'd60) begin
      n_errors++;
      $display("FAIL b2b_accept: busy=%b product=%0d, required busy=1 product=60",
               o_busy, o_product);
    end
    for (int k = 1; k <= 100; k++) begin
      if (o_done) begin
        lat2 = k;
        p2 = o_product;
        break;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (lat2 !== 7 || p2 !== 32'd12) begin
      n_errors++;
      $display("FAIL b2b_second: lat=%0d product=%0d, required lat=7 product=12", lat2, p2);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int lat; logic [31:0] p; logic v; bit sa;
    bit seen_done;
    i_a = 32'd7;
    i_b = 32'd9;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    i_reset = 1'b1;
    @(posedge clk); #1;
    i_reset = 1'b0;
    n_checks++;
    if ({o_busy, o_done, o_ovf, o_product} !== 35'd0 || o_alu_op !== 5'b10000) begin
      n_errors++;
      $display("FAIL abort_idle: busy=%b done=%b ovf=%b product=%h op=%b, required 0s op=10000",
               o_busy, o_done, o_ovf, o_product, o_alu_op);
    end
    seen_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (o_done || o_busy) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen_done !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_quiet: activity after reset=%b, required 0", seen_done);
    end
    do_mul(32'd7, 32'd9, lat, p, v, sa);
    n_checks++;
    if (lat !== 9 || p !== 32'd63 || v !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_restart: lat=%0d product=%0d ovf=%b, required lat=9 63 ovf=0",
               lat, p, v);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_overflow();
    test_back_to_back();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
